// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU.
// Decodes the IR opcode into datapath strobes and adds stall, sticky halt/resume and a retired-instruction counter.
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             stall,
  input  logic             resume,
  output logic [2:0]       ps,
  output logic             sel,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic             data_e,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic halted_r;
  logic alu_op_s;
  logic sel_s, mem_rd_s, load_ir_s, halt_s, inc_pc_s, load_ac_s, load_pc_s, mem_wr_s, data_e_s;

  // Opcodes that read an operand from memory into the accumulator.
  always_comb begin
    alu_op_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
               (opcode == OP_XOR) || (opcode == OP_LDA);
  end

  // Base per-phase decode, before stall and halt qualification.
  always_comb begin
    sel_s     = 1'b0;
    mem_rd_s  = 1'b0;
    load_ir_s = 1'b0;
    halt_s    = 1'b0;
    inc_pc_s  = 1'b0;
    load_ac_s = 1'b0;
    load_pc_s = 1'b0;
    mem_wr_s  = 1'b0;
    data_e_s  = 1'b0;
    case (ps)
      INST_ADDR: begin
        sel_s = 1'b1;
      end
      INST_FETCH: begin
        sel_s    = 1'b1;
        mem_rd_s = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel_s     = 1'b1;
        mem_rd_s  = 1'b1;
        load_ir_s = 1'b1;
      end
      OP_ADDR: begin
        inc_pc_s = 1'b1;
        halt_s   = (opcode == OP_HLT);
      end
      OP_FETCH: begin
        mem_rd_s = alu_op_s;
      end
      ALU_OP: begin
        mem_rd_s  = alu_op_s;
        load_ac_s = alu_op_s;
        inc_pc_s  = (opcode == OP_SKZ) && zero;
        load_pc_s = (opcode == OP_JMP);
        data_e_s  = (opcode == OP_STO);
      end
      STORE: begin
        mem_rd_s  = alu_op_s;
        load_ac_s = alu_op_s;
        inc_pc_s  = (opcode == OP_JMP);
        load_pc_s = (opcode == OP_JMP);
        mem_wr_s  = (opcode == OP_STO);
        data_e_s  = (opcode == OP_STO);
      end
      default: begin
        sel_s = 1'b0;
      end
    endcase
  end

  // Halt silences everything but halt; a stall suppresses only the edge-acting strobes.
  always_comb begin
    sel     = 1'b0;
    mem_rd  = 1'b0;
    load_ir = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    mem_wr  = 1'b0;
    data_e  = 1'b0;
    if (halted_r) begin
      halt = 1'b1;
    end else if (stall) begin
      sel    = sel_s;
      mem_rd = mem_rd_s;
      halt   = halt_s;
      data_e = data_e_s;
    end else begin
      sel     = sel_s;
      mem_rd  = mem_rd_s;
      load_ir = load_ir_s;
      halt    = halt_s;
      inc_pc  = inc_pc_s;
      load_ac = load_ac_s;
      load_pc = load_pc_s;
      mem_wr  = mem_wr_s;
      data_e  = data_e_s;
    end
  end

  // Phase, sticky halt and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ps          <= INST_ADDR;
      halted_r    <= 1'b0;
      instr_count <= '0;
    end else if (halted_r) begin
      // The resume edge only releases halt; the phase moves on the following edge.
      if (resume) begin
        halted_r <= 1'b0;
      end else begin
        halted_r <= 1'b1;
      end
    end else if (!stall) begin
      ps <= ps + 3'd1;
      if ((ps == OP_ADDR) && (opcode == OP_HLT)) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= 1'b0;
      end
      if (ps == STORE) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instr_count <= instr_count;
      end
    end else begin
      ps <= ps;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instruction scenarios followed by randomized
// opcode/zero/stall/resume/reset traffic, checked against an instruction-level reference model.
module tb_cpu_sequencer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_;
  logic [2:0]       opcode;
  logic             zero;
  logic             stall;
  logic             resume;
  logic [2:0]       ps;
  logic             sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e;
  logic [CNT_W-1:0] instr_count;

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .stall(stall), .resume(resume),
    .ps(ps), .sel(sel), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt), .inc_pc(inc_pc),
    .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr), .data_e(data_e),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic [2:0]       ps;
    logic [8:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: phase number, halted flag, retired count, plus inputs seen before the next edge.
  int         m_ph = 0;
  logic       m_h  = 1'b0;
  int         m_cnt = 0;
  logic       p_rst = 1'b0;
  logic [2:0] p_op  = 3'd0;
  logic       p_st  = 1'b0;
  logic       p_res = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word {sel,mem_rd,load_ir,halt,inc_pc,load_ac,load_pc,mem_wr,data_e} expressed as phase sets.
  function automatic logic [8:0] exp_ctl(int ph, int op, logic z, logic st, logic h);
    logic alu, s, mr, li, hl, ip, la, lp, mw, de;
    if (h) return 9'b0_0010_0000;
    alu = (op >= 2) && (op <= 5);
    s   = (ph <= 3);
    mr  = (ph >= 1 && ph <= 3) || (alu && ph >= 5);
    li  = (ph == 2) || (ph == 3);
    hl  = (ph == 4) && (op == 0);
    ip  = (ph == 4) || (ph == 6 && op == 1 && z) || (ph == 7 && op == 7);
    la  = alu && (ph >= 6);
    lp  = (op == 7) && (ph >= 6);
    mw  = (op == 6) && (ph == 7);
    de  = (op == 6) && (ph >= 6);
    if (st) begin
      li = 1'b0; ip = 1'b0; la = 1'b0; lp = 1'b0; mw = 1'b0;
    end
    return {s, mr, li, hl, ip, la, lp, mw, de};
  endfunction

  // One clock: account for the edge just taken, apply new inputs, push the expected response.
  task automatic step(input logic r, input logic [2:0] op, input logic z, input logic st, input logic res);
    exp_t e;
    @(posedge clk);
    #1;
    if (!p_rst) begin
      m_ph = 0; m_h = 1'b0; m_cnt = 0;
    end else if (m_h) begin
      if (p_res) m_h = 1'b0;
    end else if (!p_st) begin
      if (m_ph == 4 && p_op == 3'd0) m_h = 1'b1;
      if (m_ph == 7) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_ph = (m_ph + 1) % 8;
    end
    rst_ = r; opcode = op; zero = z; stall = st; resume = res;
    p_rst = r; p_op = op; p_st = st; p_res = res;
    if (!r) begin
      m_ph = 0; m_h = 1'b0; m_cnt = 0;
    end
    e.ps  = 3'(m_ph);
    e.ctl = exp_ctl(m_ph, int'(op), z, st, m_h);
    e.cnt = CNT_W'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [2:0] op, input logic z, input logic st, input logic res, input int n);
    for (int i = 0; i < n; i++) step(1'b1, op, z, st, res);
  endtask

  // Advance with no stall until the model reaches the requested phase (bounded to one instruction).
  task automatic goto_phase(input int ph, input logic [2:0] op);
    for (int i = 0; i < 9 && !(m_ph == ph && !m_h); i++) step(1'b1, op, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (ps !== mon_e.ps) begin
        n_fail++;
        $display("FAIL ps @%0t: got %0d expected %0d", $time, ps, mon_e.ps);
      end
      n_cmp++;
      if ({sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e} !== mon_e.ctl) begin
        n_fail++;
        $display("FAIL ctl @%0t ps=%0d op=%0d: got %b expected %b", $time, ps, opcode,
                 {sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, data_e}, mon_e.ctl);
      end
      n_cmp++;
      if (instr_count !== mon_e.cnt) begin
        n_fail++;
        $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, mon_e.cnt);
      end
    end
  end

  initial begin
    logic [2:0] cur_op;
    rst_ = 1'b0; opcode = 3'd0; zero = 1'b0; stall = 1'b0; resume = 1'b0;
    step(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    drive(3'd2, 1'b0, 1'b0, 1'b0, 9);          // ADD
    goto_phase(0, 3'd1);
    drive(3'd1, 1'b1, 1'b0, 1'b0, 8);          // SKZ taken
    drive(3'd1, 1'b0, 1'b0, 1'b0, 8);          // SKZ not taken
    drive(3'd7, 1'b0, 1'b0, 1'b0, 8);          // JMP
    drive(3'd6, 1'b0, 1'b0, 1'b0, 8);          // STO
    goto_phase(4, 3'd0);
    drive(3'd0, 1'b0, 1'b0, 1'b0, 11);         // HLT, then held
    step(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);        // stall ignored while halted
    step(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);        // resume pulse
    drive(3'd0, 1'b0, 1'b0, 1'b1, 1);          // resume when not halted is ignored
    drive(3'd0, 1'b0, 1'b0, 1'b0, 4);
    goto_phase(6, 3'd5);
    drive(3'd5, 1'b0, 1'b1, 1'b0, 3);          // LDA stalled in ALU_OP
    drive(3'd5, 1'b0, 1'b0, 1'b0, 6);
    drive(3'd6, 1'b0, 1'b0, 1'b0, 130);        // 16+ STO: counter wraps
    goto_phase(5, 3'd3);
    step(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);        // reset mid-OP_FETCH
    step(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd3, 1'b0, 1'b1, 1'b0);        // stall on first cycle after reset
    cur_op = 3'd3;
    for (int i = 0; i < 4000; i++) begin
      if (m_ph == 0 && !m_h) cur_op = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 299) != 0), cur_op, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
